// File: rtl/audio_pkg.sv
// audio_pkg -- shared types and constants for the codec audio path.
// Rev 1.0
`default_nettype none

package audio_pkg;

   localparam int AUDIO_DATA_WIDTH = 24;

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      LEFT      = 2'd1,
      RIGHT     = 2'd2
   } dac_state_t;

   typedef struct packed {
      logic [AUDIO_DATA_WIDTH-1:0] left;
      logic [AUDIO_DATA_WIDTH-1:0] right;
   } stereo_sample_t;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// sample_fifo -- synchronous show-ahead FIFO with push/pop, full/empty and occupancy count.
// Rev 1.0
`default_nettype none

module sample_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // Full gates the push regardless of a simultaneous pop.
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer -- buffers stereo pairs and shifts them out left-justified, MSB-first.
// Rev 1.0
`default_nettype none

module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] writedata_left,
   input  logic [DATA_WIDTH-1:0] writedata_right,
   output logic                  write_ready,
   input  logic                  bclk,
   input  logic                  daclrck,
   output logic                  dacdat,
   output logic                  underflow
);

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic bclk_meta_q, bclk_sync_q, bclk_dly_q;
   logic lr_meta_q,   lr_sync_q,   lr_dly_q;
   logic bclk_fall, lr_rise, lr_fall;

   logic [2*DATA_WIDTH-1:0] fifo_rdata;
   logic [DATA_WIDTH-1:0]   fifo_left, fifo_right;
   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CNT_W-1:0]        fifo_count;

   dac_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_l_q, shift_l_d;
   logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic                  dacdat_q, dacdat_d;
   logic                  underflow_q, underflow_d;

   // Synchronisers are left unreset so a reset never fabricates an LRCK edge.
   always_ff @(posedge clk) begin
      bclk_meta_q <= bclk;
      bclk_sync_q <= bclk_meta_q;
      bclk_dly_q  <= bclk_sync_q;
      lr_meta_q   <= daclrck;
      lr_sync_q   <= lr_meta_q;
      lr_dly_q    <= lr_sync_q;
   end

   assign bclk_fall = ~bclk_sync_q & bclk_dly_q;
   assign lr_rise   =  lr_sync_q & ~lr_dly_q;
   assign lr_fall   = ~lr_sync_q &  lr_dly_q;

   assign fifo_push   = write & ~fifo_full;
   assign fifo_pop    = lr_rise & ~fifo_empty;
   assign fifo_left   = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign fifo_right  = fifo_rdata[DATA_WIDTH-1:0];
   assign write_ready = (fifo_count != CNT_W'(FIFO_DEPTH));

   sample_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({writedata_left, writedata_right}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SYNC_WAIT;
         shift_l_q   <= '0;
         hold_r_q    <= '0;
         bit_idx_q   <= '0;
         dacdat_q    <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_l_q   <= shift_l_d;
         hold_r_q    <= hold_r_d;
         bit_idx_q   <= bit_idx_d;
         dacdat_q    <= dacdat_d;
         underflow_q <= underflow_d;
      end
   end

   // LR strobes take priority; a coincident BCLK fall is dropped.
   always_comb begin
      state_d     = state_q;
      shift_l_d   = shift_l_q;
      hold_r_d    = hold_r_q;
      bit_idx_d   = bit_idx_q;
      dacdat_d    = dacdat_q;
      underflow_d = 1'b0;

      if (lr_rise) begin
         state_d   = LEFT;
         bit_idx_d = IDX_W'(DATA_WIDTH-1);
         if (!fifo_empty) begin
            shift_l_d = fifo_left;
            hold_r_d  = fifo_right;
         end else begin
            shift_l_d   = '0;
            hold_r_d    = '0;
            underflow_d = 1'b1;
         end
         dacdat_d = shift_l_d[DATA_WIDTH-1];
      end else if (lr_fall && (state_q == LEFT)) begin
         state_d   = RIGHT;
         shift_l_d = hold_r_q;
         dacdat_d  = hold_r_q[DATA_WIDTH-1];
         bit_idx_d = IDX_W'(DATA_WIDTH-1);
      end else if (bclk_fall && (state_q != SYNC_WAIT)) begin
         if (bit_idx_q != '0) begin
            shift_l_d = shift_l_q << 1;
            dacdat_d  = shift_l_d[DATA_WIDTH-1];
            bit_idx_d = bit_idx_q - 1'b1;
         end else begin
            dacdat_d = 1'b0;
         end
      end else if (state_q == SYNC_WAIT) begin
         dacdat_d = 1'b0;
      end
   end

   assign dacdat    = dacdat_q;
   assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer -- directed, table-driven bench for audio_dac_serializer.
// Rev 1.0
`default_nettype none

module tb_audio_dac_serializer;
   import audio_pkg::*;

   localparam int DW        = AUDIO_DATA_WIDTH;
   localparam int BCLK_HALF = 8;

   typedef struct {
      stereo_sample_t s;
      logic [31:0]    exp_l;
      logic [31:0]    exp_r;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write = 1'b0;
   logic [DW-1:0] wl = '0;
   logic [DW-1:0] wr = '0;
   logic          bclk = 1'b1;
   logic          daclrck = 1'b0;
   logic          write_ready;
   logic          dacdat;
   logic          underflow;

   int checks = 0;
   int failures = 0;
   int uf_total = 0;

   always #5 clk = ~clk;

   audio_dac_serializer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .write           (write),
      .writedata_left  (wl),
      .writedata_right (wr),
      .write_ready     (write_ready),
      .bclk            (bclk),
      .daclrck         (daclrck),
      .dacdat          (dacdat),
      .underflow       (underflow)
   );

   always @(negedge clk) begin
      if (underflow) uf_total = uf_total + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(negedge clk);
      write = 1'b1;
      wl    = l;
      wr    = r;
      @(negedge clk);
      write = 1'b0;
   endtask

   // BCLK periods first..first+n-1 of a 64-BCLK frame; LRCK rises at 0, falls at 32.
   task automatic run_bclks(input int first, input int n,
                            output logic [31:0] lw, output logic [31:0] rw);
      lw = '0;
      rw = '0;
      @(negedge clk);
      for (int i = first; i < first + n; i++) begin
         bclk = 1'b0;
         if (i == 0)  daclrck = 1'b1;
         if (i == 32) daclrck = 1'b0;
         repeat (BCLK_HALF) @(negedge clk);
         if (i < 32) lw = {lw[30:0], dacdat};
         else        rw = {rw[30:0], dacdat};
         bclk = 1'b1;
         repeat (BCLK_HALF) @(negedge clk);
      end
   endtask

   vec_t        vecs [4];
   logic [31:0] lw, rw;
   int          uf_start;
   bit          seen;
   stereo_sample_t fill [5];

   initial begin
      vecs[0].s.left = 24'hA5A5A5; vecs[0].s.right = 24'h5A5A5A;
      vecs[0].exp_l  = 32'hA5A5A5_00; vecs[0].exp_r = 32'h5A5A5A_00;
      vecs[1].s.left = 24'h800001; vecs[1].s.right = 24'h7FFFFF;
      vecs[1].exp_l  = 32'h800001_00; vecs[1].exp_r = 32'h7FFFFF_00;
      vecs[2].s.left = 24'hFFFFFF; vecs[2].s.right = 24'h000000;
      vecs[2].exp_l  = 32'hFFFFFF_00; vecs[2].exp_r = 32'h000000_00;
      vecs[3].s.left = 24'h123456; vecs[3].s.right = 24'hABCDEF;
      vecs[3].exp_l  = 32'h123456_00; vecs[3].exp_r = 32'hABCDEF_00;

      fill[0].left = 24'h111111; fill[0].right = 24'h222222;
      fill[1].left = 24'h333333; fill[1].right = 24'h444444;
      fill[2].left = 24'h555555; fill[2].right = 24'h666666;
      fill[3].left = 24'h777777; fill[3].right = 24'h888888;
      fill[4].left = 24'h999999; fill[4].right = 24'hAAAAAA;

      // Reset and idle
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("reset_dacdat", {31'd0, dacdat}, 32'd0);
      check("reset_write_ready", {31'd0, write_ready}, 32'd1);
      check("reset_underflow", {31'd0, underflow}, 32'd0);

      // One pair per frame
      for (int v = 0; v < 4; v++) begin
         push_pair(vecs[v].s.left, vecs[v].s.right);
         run_bclks(0, 64, lw, rw);
         check($sformatf("vec%0d_left", v), lw, vecs[v].exp_l);
         check($sformatf("vec%0d_right", v), rw, vecs[v].exp_r);
      end

      // Fill to full; fifth push must be dropped
      for (int k = 0; k < 4; k++) push_pair(fill[k].left, fill[k].right);
      check("full_write_ready", {31'd0, write_ready}, 32'd0);
      push_pair(fill[4].left, fill[4].right);
      check("full_after_5th", {31'd0, write_ready}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         run_bclks(0, 64, lw, rw);
         if (k == 0) check("drain_write_ready", {31'd0, write_ready}, 32'd1);
         check($sformatf("fill%0d_left", k), lw, {fill[k].left, 8'h00});
         check($sformatf("fill%0d_right", k), rw, {fill[k].right, 8'h00});
      end

      // Frame with FIFO empty
      uf_start = uf_total;
      run_bclks(0, 64, lw, rw);
      check("underflow_pulses", uf_total - uf_start, 32'd1);
      check("underflow_left", lw, 32'd0);
      check("underflow_right", rw, 32'd0);

      // Push held high at full while a frame start pops
      for (int k = 0; k < 4; k++) push_pair(fill[k].left, fill[k].right);
      @(negedge clk);
      write   = 1'b1;
      wl      = fill[4].left;
      wr      = fill[4].right;
      daclrck = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (write_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check("pop_frees_slot", {31'd0, seen}, 32'd1);
      @(negedge clk);
      check("held_push_refills", {31'd0, write_ready}, 32'd0);
      write = 1'b0;
      repeat (10) @(negedge clk);
      daclrck = 1'b0;
      repeat (10) @(negedge clk);
      for (int k = 1; k < 5; k++) begin
         run_bclks(0, 64, lw, rw);
         check($sformatf("held%0d_left", k), lw, {fill[k].left, 8'h00});
         check($sformatf("held%0d_right", k), rw, {fill[k].right, 8'h00});
      end

      // Reset mid-word flushes output and FIFO
      push_pair(24'h800001, 24'h000000);
      push_pair(24'h7FFFFF, 24'h7FFFFF);
      run_bclks(0, 10, lw, rw);
      check("partial_bits", lw, 32'h200);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_dacdat", {31'd0, dacdat}, 32'd0);
      check("midreset_write_ready", {31'd0, write_ready}, 32'd1);
      uf_start = uf_total;
      run_bclks(32, 16, lw, rw);
      check("sync_wait_hold", rw, 32'd0);
      check("sync_wait_no_uf", uf_total - uf_start, 32'd0);
      run_bclks(0, 64, lw, rw);
      check("post_reset_underflow", uf_total - uf_start, 32'd1);
      check("post_reset_left", lw, 32'd0);
      check("post_reset_right", rw, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Transmit-side counterpart to the codec's ADC deserializer.
- Accepts stereo sample pairs from user logic over the same `write`/`write_ready` handshake the filter path drives.
- Buffers the pairs in a small FIFO and shifts them out MSB-first on the DAC serial line, timed by the codec-mastered BCLK and DACLRCK.
- Sits between user audio logic and the AUD_DACDAT pin, in the CLOCK_50 domain.

Parameters:
- DATA_WIDTH, 24, bits per channel sample.
- FIFO_DEPTH, 4, number of stereo pairs buffered; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock (CLOCK_50).
- reset  input  1  synchronous, active-high reset.
- write  input  1  push request; samples are accepted when write & write_ready.
- writedata_left  input  DATA_WIDTH  left-channel sample, two's complement.
- writedata_right  input  DATA_WIDTH  right-channel sample, two's complement.
- write_ready  output  1  high when the FIFO is not full.
- bclk  input  1  codec bit clock (AUD_BCLK); asynchronous to clk.
- daclrck  input  1  codec DAC word clock (AUD_DACLRCK); high = left, low = right; asynchronous to clk.
- dacdat  output  1  serial data to the codec (AUD_DACDAT), registered.
- underflow  output  1  one-cycle pulse when a frame starts with the FIFO empty.

Behaviour:
- Interface (already decided): one clock, `clk`; `reset` is synchronous and active-high.
- Reset values:
  - dacdat=0, underflow=0, write_ready=1.
  - FIFO emptied, count=0, state=SYNC_WAIT, bit_idx=0, shift registers 0.
  - Reset asserted mid-word flushes everything; no partial output resumes after it.
- Synchronisation and edge detection:
  - bclk and daclrck each pass through 2-flop synchronisers, then a delay register for edge detection.
  - lr_rise, lr_fall, and bclk_fall are single-cycle strobes.
  - Strobe latency is 3 clk after the pin transition.
- FIFO:
  - Entry = {left,right}; write_ready = (count != FIFO_DEPTH), combinational from count.
  - A push when full is ignored.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, a push is rejected even if a pop occurs in that same cycle.
- State machine (SYNC_WAIT, LEFT, RIGHT):
  - SYNC_WAIT: dacdat=0; pushes accepted. lr_rise -> LEFT (with frame-start actions).
  - lr_rise in any state: frame start; go to LEFT.
    - If FIFO non-empty: pop; load left word into shift_l and right word into hold_r.
    - If FIFO empty: load zeros into both and pulse underflow.
    - dacdat <= MSB of the left word; bit_idx <= DATA_WIDTH-1.
  - lr_fall in LEFT: go to RIGHT; load shift_l <= hold_r; dacdat <= its MSB; bit_idx <= DATA_WIDTH-1.
  - lr_fall in SYNC_WAIT: ignored.
  - bclk_fall in LEFT/RIGHT with no LR strobe in the same cycle:
    - If bit_idx > 0: shift left by one; dacdat <= new MSB; bit_idx--.
    - Otherwise dacdat <= 0 (padding until the next LR edge).
  - An LR strobe and bclk_fall in the same cycle: the LR strobe wins and bclk_fall is dropped.
  - Left-justified format: MSB valid from the LRCK edge; the codec samples on the BCLK rising edge.
- Widths: bit_idx is $clog2(DATA_WIDTH) bits; FIFO count is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- No combinational path from bclk or daclrck to dacdat.

Decomposition:
- Shared package `audio_pkg`:
  - AUDIO_DATA_WIDTH = 24.
  - typedef enum {SYNC_WAIT, LEFT, RIGHT} dac_state_t.
  - typedef struct packed {logic [W-1:0] left, right;} stereo_sample_t.
- One sub-module: `sample_fifo`, a synchronous FIFO parameterised by width and depth, with push, pop, full, empty and count.
- Synchronisers and edge detection stay inline.

Test Plan:
- Reset then idle, no LRCK edges -> dacdat=0, write_ready=1, underflow=0; a write of L=24'hA5A5A5, R=24'h5A5A5A is accepted.
- Push the pair above, then drive one frame (LRCK high for 32 BCLKs, then low for 32).
  - dacdat bits sampled at BCLK rising edges read 24'hA5A5A5 then 8 zeros.
  - Next half-frame reads 24'h5A5A5A then 8 zeros.
- Push 4 pairs with no frames -> write_ready=0 after the 4th; a 5th write is ignored.
  - One frame later write_ready=1, and the serialized words match pair #1.
- Frame start with the FIFO empty -> underflow high for exactly 1 clk; dacdat=0 for the whole frame.
- write held high at full while lr_rise pops -> count goes 4->3; write_ready=1 the next cycle; the following push is accepted and count returns to 4.
- Assert reset after 10 bits of the left word 24'h800001 -> dacdat=0 next cycle; FIFO empty; SYNC_WAIT holds through a subsequent lr_fall; the next lr_rise gives an underflow pulse.
